jmp_ctrl: RTL

Execute-stage consumer of the jump fields held in the decode/execute pipeline latch. It samples `new_jmp`, `jmp_type`, `jmp_imm` and `jal_rs`, resolves the branch condition against the execute operands, and issues a one-cycle PC redirect. It flushes the upstream fetch/decode latches for a fixed drain window and writes the link address for JAL/JALR. It closes the loop on the latch: the latch carries jump requests forward, and this block drives the latch's `reset` (flush) and `en` (hold) back.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/branch_cmp.sv | 28 ++
 rtl/jmp_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: jump-type encodings used by the decoder that fills
// the decode/execute latch, and the jump controller FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] JMP_JAL  = 3'd0;
  localparam logic [2:0] JMP_JALR = 3'd1;
  localparam logic [2:0] JMP_BEQ  = 3'd2;
  localparam logic [2:0] JMP_BNE  = 3'd3;
  localparam logic [2:0] JMP_BLT  = 3'd4;
  localparam logic [2:0] JMP_BGE  = 3'd5;
  localparam logic [2:0] JMP_BLTU = 3'd6;
  localparam logic [2:0] JMP_BGEU = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } jmp_state_e;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition resolver: decides whether a jump request is taken from the
// execute operands. JAL and JALR are unconditional.
module branch_cmp
  import cpu_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  jmp_type,
  output logic        taken
);

  // Compare operands according to the jump type
  always_comb begin
    taken = 1'b0;
    case (jmp_type)
      JMP_JAL:  taken = 1'b1;
      JMP_JALR: taken = 1'b1;
      JMP_BEQ:  taken = (rs1 == rs2);
      JMP_BNE:  taken = (rs1 != rs2);
      JMP_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      JMP_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      JMP_BLTU: taken = (rs1 <  rs2);
      JMP_BGEU: taken = (rs1 >= rs2);
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/jmp_ctrl.sv
// Execute-stage jump controller. Consumes jump requests from the
// decode/execute latch, resolves them, issues a one-cycle PC redirect, flushes
// fetch/decode for FLUSH_CYCLES cycles and writes the JAL/JALR link register.
//
// Handshake: new_jmp is a plain valid with no ready. It is consumed on any
// edge where the FSM is IDLE; while FLUSH is active it is dropped on purpose,
// since those requests come from wrong-path instructions. hold_n low tells the
// latch to hold, flush high tells it to clear.
module jmp_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_jmp,
  input  logic [2:0]       jmp_type,
  input  logic [31:0]      jmp_imm,
  input  logic [5:0]       jal_rs,
  input  logic [31:0]      pc_ex,
  input  logic [31:0]      rs1_val,
  input  logic [31:0]      rs2_val,
  output logic             redirect,
  output logic [31:0]      pc_target,
  output logic             flush,
  output logic             hold_n,
  output logic             link_we,
  output logic [5:0]       link_addr,
  output logic [31:0]      link_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  jmp_state_e       state, state_d;
  logic [2:0]       fcnt, fcnt_d;
  logic             taken;
  logic             is_link;
  logic             is_jalr;
  logic [31:0]      target;
  logic             misaligned;

  logic             redirect_d;
  logic [31:0]      pc_target_d;
  logic             flush_d;
  logic             link_we_d;
  logic [5:0]       link_addr_d;
  logic [31:0]      link_data_d;
  logic             misalign_d;
  logic [CNT_W-1:0] taken_cnt_d;

  branch_cmp u_branch_cmp (
    .rs1      (rs1_val),
    .rs2      (rs2_val),
    .jmp_type (jmp_type),
    .taken    (taken)
  );

  assign is_jalr = (jmp_type == JMP_JALR);
  assign is_link = (jmp_type == JMP_JAL) || is_jalr;

  // Target adder: JALR is register-relative with bit 0 cleared, the rest are
  // PC-relative; both wrap at 32 bits
  always_comb begin
    target = pc_ex + jmp_imm;
    if (is_jalr) begin
      target = (rs1_val + jmp_imm) & 32'hFFFF_FFFE;
    end
  end

  // Alignment is checked on PC-relative targets; a JALR target is used as the
  // register computation gives it once bit 0 is cleared
  always_comb begin
    misaligned = 1'b0;
    if (!is_jalr) begin
      misaligned = (target[1:0] != 2'b00);
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d     = state;
    fcnt_d      = fcnt;
    redirect_d  = 1'b0;
    link_we_d   = 1'b0;
    pc_target_d = pc_target;
    link_addr_d = link_addr;
    link_data_d = link_data;
    misalign_d  = misalign_err;
    taken_cnt_d = taken_cnt;
    case (state)
      ST_IDLE: begin
        if (new_jmp && taken) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            redirect_d  = 1'b1;
            pc_target_d = target;
            state_d     = ST_FLUSH;
            fcnt_d      = FLUSH_LOAD;
            if (taken_cnt != {CNT_W{1'b1}}) begin
              taken_cnt_d = taken_cnt + CNT_W'(1);
            end
            if (is_link && (jal_rs != 6'd0)) begin
              link_we_d   = 1'b1;
              link_addr_d = jal_rs;
              link_data_d = pc_ex + 32'd4;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (fcnt == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    flush_d = (state_d == ST_FLUSH);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      fcnt         <= 3'd0;
      redirect     <= 1'b0;
      pc_target    <= 32'd0;
      flush        <= 1'b0;
      hold_n       <= 1'b1;
      link_we      <= 1'b0;
      link_addr    <= 6'd0;
      link_data    <= 32'd0;
      misalign_err <= 1'b0;
      taken_cnt    <= '0;
    end else begin
      state        <= state_d;
      fcnt         <= fcnt_d;
      redirect     <= redirect_d;
      pc_target    <= pc_target_d;
      flush        <= flush_d;
      hold_n       <= !flush_d;
      link_we      <= link_we_d;
      link_addr    <= link_addr_d;
      link_data    <= link_data_d;
      misalign_err <= misalign_d;
      taken_cnt    <= taken_cnt_d;
    end
  end

endmodule
